// File: rtl/conv_host_mem_if.sv
// CONV engine <-> host memory bus: start handshake, image read port and result
// write/read ports. The memory block uses the slave modport, the engine the master.
interface conv_host_mem_if #(
  parameter int DW = 20
);
  logic          ready;
  logic          busy;
  logic [11:0]   iaddr;
  logic [DW-1:0] idata;
  logic          cwr;
  logic [11:0]   caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [11:0]   caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;

  modport master (
    input  ready, idata, cdata_rd,
    output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport slave (
    output ready, idata, cdata_rd,
    input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );
endinterface

// File: rtl/conv_host_mem.sv
// Host-side memory block for the CONV engine: image ROM, L0/L1 result memories,
// job handshake and statistics. Optional watchdog enabled by CONV_HOST_TIMEOUT_EN.
module conv_host_mem #(
  parameter int IMG_DEPTH = 4096,
  parameter int L0_DEPTH  = 4096,
  parameter int L1_DEPTH  = 1024,
  parameter int DW        = 20,
  parameter int TIMEOUT   = 200000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_en,
  input  logic [11:0]   ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          dump_sel,
  input  logic [11:0]   dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          done,
  output logic          err,
  output logic [12:0]   wr_cnt_l0,
  output logic [10:0]   wr_cnt_l1,
  conv_host_mem_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t        state_r, state_nxt;
  logic          busy_prev_r;
  logic          ready_r;
  logic [DW-1:0] idata_r;
  logic [DW-1:0] cdata_rd_r;
  logic          timeout_s;

  logic          job_start_s;
  logic          wr_l0_s, wr_l1_s, wr_bad_s;
  logic          rd_l0_s, rd_l1_s, rd_bad_s;
  logic          err_set_s, err_nxt;
  logic [12:0]   cnt_l0_base_s, cnt_l0_nxt;
  logic [10:0]   cnt_l1_base_s, cnt_l1_nxt;

  logic [DW-1:0] img_mem [IMG_DEPTH];
  logic [DW-1:0] l0_mem  [L0_DEPTH];
  logic [DW-1:0] l1_mem  [L1_DEPTH];

`ifdef CONV_HOST_TIMEOUT_EN
  logic [17:0] wdog_r;

  // Watchdog restarts on every state change and counts while waiting in ARM/RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_r <= 18'd0;
    end else if (state_nxt != state_r) begin
      wdog_r <= 18'd0;
    end else if (state_r == ARM || state_r == RUN) begin
      wdog_r <= wdog_r + 18'd1;
    end else begin
      wdog_r <= 18'd0;
    end
  end

  assign timeout_s = (state_r == ARM || state_r == RUN) && (wdog_r == 18'(TIMEOUT - 1));
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT;
  assign timeout_s        = 1'b0;
`endif

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt = ARM;
        else       state_nxt = IDLE;
      end
      ARM: begin
        if (timeout_s)     state_nxt = DONE;
        else if (bus.busy) state_nxt = RUN;
        else               state_nxt = ARM;
      end
      RUN: begin
        if (timeout_s)                      state_nxt = DONE;
        else if (busy_prev_r && !bus.busy)  state_nxt = DONE;
        else                                state_nxt = RUN;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    job_start_s = (state_r == IDLE) && start;

    wr_l0_s  = bus.cwr && (bus.csel == 3'b001);
    wr_l1_s  = bus.cwr && (bus.csel == 3'b011) && (bus.caddr_wr[11:10] == 2'b00);
    wr_bad_s = bus.cwr && !wr_l0_s && !wr_l1_s;
    rd_l0_s  = bus.crd && (bus.csel == 3'b001);
    rd_l1_s  = bus.crd && (bus.csel == 3'b011) && (bus.caddr_rd[11:10] == 2'b00);
    rd_bad_s = bus.crd && !rd_l0_s && !rd_l1_s;

    // Any protocol violation this cycle; the clear on job start loses to a fresh violation.
    err_set_s = wr_bad_s || rd_bad_s
             || ((bus.cwr || bus.crd) && (state_r != RUN))
             || (ld_en && (state_r == ARM || state_r == RUN))
             || ((state_r == IDLE) && bus.busy && !busy_prev_r)
             || timeout_s;
    err_nxt   = (job_start_s ? 1'b0 : err) | err_set_s;

    cnt_l0_base_s = job_start_s ? 13'd0 : wr_cnt_l0;
    cnt_l1_base_s = job_start_s ? 11'd0 : wr_cnt_l1;
    if (wr_l0_s && (cnt_l0_base_s != {13{1'b1}})) cnt_l0_nxt = cnt_l0_base_s + 13'd1;
    else                                          cnt_l0_nxt = cnt_l0_base_s;
    if (wr_l1_s && (cnt_l1_base_s != {11{1'b1}})) cnt_l1_nxt = cnt_l1_base_s + 11'd1;
    else                                          cnt_l1_nxt = cnt_l1_base_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      busy_prev_r <= 1'b0;
      ready_r     <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      wr_cnt_l0   <= 13'd0;
      wr_cnt_l1   <= 11'd0;
      idata_r     <= '0;
      cdata_rd_r  <= '0;
      dump_data   <= '0;
    end else begin
      state_r     <= state_nxt;
      busy_prev_r <= bus.busy;
      ready_r     <= (state_nxt == ARM);
      done        <= (state_nxt == DONE);
      err         <= err_nxt;
      wr_cnt_l0   <= cnt_l0_nxt;
      wr_cnt_l1   <= cnt_l1_nxt;
      idata_r     <= img_mem[bus.iaddr];
      dump_data   <= dump_sel ? l1_mem[dump_addr[9:0]] : l0_mem[dump_addr];
      if (rd_l0_s)       cdata_rd_r <= l0_mem[bus.caddr_rd];
      else if (rd_l1_s)  cdata_rd_r <= l1_mem[bus.caddr_rd[9:0]];
      else if (rd_bad_s) cdata_rd_r <= '0;
    end
  end

  // Memory arrays have no reset; non-blocking writes give read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (ld_en)   img_mem[ld_addr]             <= ld_data;
    if (wr_l0_s) l0_mem[bus.caddr_wr]         <= bus.cdata_wr;
    if (wr_l1_s) l1_mem[bus.caddr_wr[9:0]]    <= bus.cdata_wr;
  end

  assign bus.ready    = ready_r;
  assign bus.idata    = idata_r;
  assign bus.cdata_rd = cdata_rd_r;

endmodule
